// File: rtl/press_conditioner_pkg.sv
// ============================================================================
// Module      : press_conditioner_pkg
// Description : Shared types and constants for the push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package press_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

endpackage

`default_nettype wire

// File: rtl/press_conditioner_btn_sync.sv
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchronizer for the raw, asynchronous button input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
    end
  end

  assign sync_out = r_s2;

endmodule

`default_nettype wire

// File: rtl/press_conditioner.sv
// ============================================================================
// Module      : press_conditioner
// Description : Synchronize, debounce and pulse-shape a push button; exports
//               the debounced level and a saturating rejected-bounce count.
//               Define PRESS_CONDITIONER_REPEAT_EN for auto-repeat while held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_conditioner
  import press_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  output logic                press,
  output logic                btn_level,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                w_sync;
  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_glitch;
  logic                w_accept;
  logic                w_reenter;
  logic                w_rep_fire;
  logic                r_press;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  btn_sync u_btn_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (btn_in),
    .sync_out (w_sync)
  );

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_glitch   = 1'b0;
    w_accept   = 1'b0;
    w_reenter  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_next     = DB_PRESS;
          w_cnt_next = '0;
        end
      end
      DB_PRESS: begin
        if (!w_sync) begin
          w_next   = IDLE;
          w_glitch = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next   = HELD;
          w_accept = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_sync) begin
          w_next     = DB_RELEASE;
          w_cnt_next = '0;
        end
      end
      DB_RELEASE: begin
        if (w_sync) begin
          w_next    = HELD;
          w_glitch  = 1'b1;
          w_reenter = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_press      <= 1'b0;
      r_glitch_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_press <= w_accept | w_rep_fire;
      if (w_glitch && (r_glitch_cnt != GLITCH_MAX)) begin
        r_glitch_cnt <= r_glitch_cnt + 1'b1;
      end
    end
  end

`ifdef PRESS_CONDITIONER_REPEAT_EN
  localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_repeating;

  // First target is the hold delay; after the first repeat the period applies.
  assign w_rep_fire = (r_state == HELD) && w_sync &&
                      (r_rep_cnt == (r_repeating ? REP_LAST : HOLD_LAST));

  always_ff @(posedge clk) begin
    if (rst || w_accept || w_reenter) begin
      r_rep_cnt   <= '0;
      r_repeating <= 1'b0;
    end else if ((r_state == HELD) && w_sync) begin
      if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_repeating <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  // Both parameters are legal only when >= 1, so this folds to constant 0.
  assign w_rep_fire = (HOLD_CYCLES < 0) || (REPEAT_CYCLES < 0);
`endif

  assign press      = r_press;
  assign btn_level  = (r_state == HELD) || (r_state == DB_RELEASE);
  assign glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_press_conditioner.sv
// ============================================================================
// Module      : tb_press_conditioner
// Description : Self-checking bench for press_conditioner against a
//               run-length reference model of the debounce rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_press_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       press;
  logic       btn_level;
  logic [7:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: two-sample delay line, level, disagreement run,
  // age inside the held level, and the bounce count.
  bit pipe[$];
  bit m_level;
  bit m_press;
  int m_run;
  int m_age;
  int m_glitch;

  press_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .press      (press),
    .btn_level  (btn_level),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // A level flips once DEB+1 consecutive synchronized samples disagree with it;
  // a disagreement run that ends earlier counts as a rejected bounce.
  task automatic model_step(input bit r, input bit b);
    bit s;
    m_press = 1'b0;
    if (r) begin
      pipe     = '{1'b0, 1'b0};
      m_level  = 1'b0;
      m_run    = 0;
      m_age    = 0;
      m_glitch = 0;
    end else begin
      s = pipe.pop_front();
      pipe.push_back(b);
      if (s != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = !m_level;
          m_run   = 0;
          m_age   = 0;
          if (m_level) m_press = 1'b1;
        end
      end else begin
        if (m_run > 0) begin
          if (m_glitch < 255) m_glitch++;
          m_age = 0;
        end else if (m_level) begin
          m_age++;
`ifdef PRESS_CONDITIONER_REPEAT_EN
          if (m_age == HOLD || (m_age > HOLD && ((m_age - HOLD) % REP) == 0))
            m_press = 1'b1;
`endif
        end
        m_run = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit b);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    check_val("press", 32'(press), 32'(m_press));
    check_val("btn_level", 32'(btn_level), 32'(m_level));
    check_val("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
  endtask

  task automatic run_level(input bit b, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, b);
  endtask

  initial begin
    int presses;
    bit v;

    // Reset and quiet idle
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    run_level(1'b0, 10);

    // Clean press and release; count pulses seen on the DUT
    presses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1);
      if (press) presses++;
    end
`ifndef PRESS_CONDITIONER_REPEAT_EN
    check_val("single_press", 32'(presses), 32'd1);
`endif
    check_val("held_level", 32'(btn_level), 32'd1);
    run_level(1'b0, 12);
    check_val("released_level", 32'(btn_level), 32'd0);

    // Bounce while held is absorbed
    run_level(1'b1, 12);
    run_level(1'b0, 3);
    run_level(1'b1, 10);
    run_level(1'b0, 12);

    // Reset in the middle of press debounce, button kept high
    run_level(1'b1, 4);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    run_level(1'b1, 14);
    run_level(1'b0, 12);

    // Long hold for auto-repeat builds
    run_level(1'b1, 30);
    run_level(1'b0, 12);

    // Randomized bursts with occasional resets
    for (int k = 0; k < 250; k++) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        cycle(1'b1, v);
      end
      run_level(v, $urandom_range(1, 12));
    end
    run_level(1'b0, 12);

    // Short bounces until the counter saturates
    cycle(1'b1, 1'b0);
    run_level(1'b0, 4);
    for (int k = 0; k < 300; k++) begin
      run_level(1'b1, 3);
      run_level(1'b0, 5);
    end
    check_val("glitch_sat", 32'(glitch_cnt), 32'd255);
    check_val("no_level_after_bounces", 32'(btn_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
